gcd_client: RTL
===============

# gcd_client

Front-end adapter placed directly upstream of the GCD core. It accepts operand pairs on a ready/valid input and runs the core's four-phase req/ack protocol on a single shared load bus: operand A first, then operand B. It captures the core's result and returns it on a ready/valid output, together with a measured latency count. Zero operands can optionally be resolved locally, because the core never terminates on them.

## Interface
- `W`, 16, operand/result width; must match the core's `W`
- `CW`, 8, width of latency counter
- `clock` in 1: clock
- `reset` in 1: synchronous, active-high; also drives the core's reset
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: client idle, can accept
- `in_a` in W: first operand
- `in_b` in W: second operand
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `out_result` out W: gcd(a,b)
- `out_cycles` out CW: cycles from accept to `out_valid`, saturating
- `gcd_req` out 1: to core `req`
- `gcd_ack` in 1: from core `ack`
- `gcd_load_val` out W: to core `loadVal`
- `gcd_result` in W: from core `result`

## Operation
- States: IDLE, REQ_A, REL_A, REQ_B, REL_B, RESP.
- IDLE: `in_ready`=1. On `in_valid`, register `in_a`/`in_b` into a_q/b_q, set cnt=1, and go to REQ_A (or RESP when bypassing; see Configuration).
- REQ_A: `gcd_req`=1, `gcd_load_val`=a_q. When `gcd_ack`=1, go to REL_A.
- REL_A: `gcd_req`=0, `gcd_load_val`=a_q. When `gcd_ack`=0, go to REQ_B.
- REQ_B: `gcd_req`=1, `gcd_load_val`=b_q. When `gcd_ack`=1, latch `gcd_result` into r_q and go to REL_B.
- REL_B: `gcd_req`=0. When `gcd_ack`=0, go to RESP.
- RESP: `out_valid`=1, `out_result`=r_q, `out_cycles`=cnt. When `out_ready`=1, go to IDLE.
- `gcd_req` decodes from the registered state only; it has no combinational path from `gcd_ack`.
- `gcd_load_val` is stable for the whole period `gcd_req` is high and for the cycle in which it rises.
- `gcd_req` rises only after `gcd_ack` has been observed low (strict four-phase).
- cnt increments every cycle in states other than IDLE and RESP, and saturates at 2^CW-1.
- `gcd_ack` high in IDLE or RESP is ignored.
- Reset in any state: IDLE; a_q, b_q, r_q and cnt are cleared. Any in-flight operation is dropped without an output.
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_cycles`=0, `gcd_req`=0, `gcd_load_val`=0.

## Timing
- Accept happens at cycle 0.
- REQ_A occupies cycle 1; the core acks at cycle 2.
- REL_A occupies cycle 3; ack drops at cycle 4.
- REQ_B occupies cycle 5.
- With a==b, the core acks at cycle 7, REL_B is reached at cycle 8, and `out_valid` rises at cycle 10 with `out_cycles`=10.
- Each core subtract step adds 2 cycles.
- Bypass path: `out_valid` at cycle 1, `out_cycles`=1.
- Throughput: one operation in flight. `in_ready` returns 1 the cycle after the output handshake.
- `out_valid`/`out_result` hold stable until `out_ready`.

## Configuration
- `GCD_CLIENT_ZERO_BYPASS_EN` defined:
  - If in_a==0 or in_b==0, skip the core entirely and go IDLE→RESP with r_q = in_a | in_b.
  - Examples: gcd(0,x)=x, gcd(0,0)=0.
- Undefined:
  - All pairs are forwarded to the core.
  - The upstream source must not issue zero operands; a zero operand alongside a nonzero one hangs the core, and the client stalls in REQ_B.

## Structure
- `gcd_client_pkg`: `state_t` enum (3-bit) and the default-width constants.
- One sub-module, `gcd_lat_counter`: a CW-bit saturating counter with clear/enable inputs.
- Top-level wiring: `gcd_client` and the core share `clock`/`reset`.

## Test plan
- (6,6) with `out_ready`=1 → `out_result`=6, `out_valid` at cycle 10, `out_cycles`=10.
- (12,8) → result 4, `out_cycles`=14. Check `gcd_load_val`=12 during REQ_A/REL_A and 8 during REQ_B.
- Back-to-back (48,18), (17,5) with `out_ready` held low for 5 cycles → results 6 then 1, output held stable, `in_ready`=0 until drained.
- With `GCD_CLIENT_ZERO_BYPASS_EN`: (0,9) → 9 and (0,0) → 0, each with `out_cycles`=1 and `gcd_req` never asserted.
- Reset pulse during REQ_B of (100,75) → `gcd_req`=0 and `in_ready`=1 next cycle, no `out_valid`; the following (100,75) returns 25.
- CW=4 with (255,1) → `out_cycles` saturates at 15; result 1.

Source files
------------

// File: rtl/gcd_client_pkg.sv
// ----------------------------------------------------------------------------
// gcd_client_pkg
//   Shared definitions for the GCD core front-end adapter.
//   - state_t             : client sequencer states (3-bit encoding)
//   - GCD_W_DEFAULT       : default operand/result width (must match the core)
//   - GCD_CW_DEFAULT      : default latency counter width
//   - state_counts()      : true in the states where the latency counter runs
// ----------------------------------------------------------------------------
package gcd_client_pkg;

  localparam int GCD_W_DEFAULT  = 16;
  localparam int GCD_CW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    REL_A = 3'd2,
    REQ_B = 3'd3,
    REL_B = 3'd4,
    RESP  = 3'd5
  } state_t;

  // The accept cycle is counted by loading 1; after that every cycle spent
  // talking to the core counts, while waiting in IDLE or RESP does not.
  function automatic logic state_counts(input state_t s);
    return (s != IDLE) && (s != RESP);
  endfunction

endpackage

// File: rtl/gcd_lat_counter.sv
// ----------------------------------------------------------------------------
// gcd_lat_counter
//   CW-bit saturating latency counter.
//   Ports:
//     clock   in  : clock
//     reset   in  : synchronous active-high reset, clears the count to 0
//     clear   in  : restart a measurement; loads 1 because the cycle in which
//                   the restart happens is itself part of the measurement
//     enable  in  : count one more cycle (ignored while clear is high)
//     count   out : current count, sticks at all-ones once reached
// ----------------------------------------------------------------------------
module gcd_lat_counter
  import gcd_client_pkg::*;
#(
  parameter int CW = GCD_CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = CNT_ONE;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/gcd_client.sv
// ----------------------------------------------------------------------------
// gcd_client
//   Front-end adapter sitting directly upstream of the GCD core. Accepts an
//   operand pair on a ready/valid input, feeds the core over its four-phase
//   req/ack protocol on one shared load bus (operand A, then operand B),
//   captures the core's result and returns it on a ready/valid output along
//   with the number of cycles the operation took (saturating).
//
//   Optional feature macro: GCD_CLIENT_ZERO_BYPASS_EN
//     When defined, a pair with a zero operand never reaches the core (the
//     core would never terminate on it); the result in_a | in_b is returned
//     one cycle after accept. When undefined, every pair goes to the core and
//     the source must not issue zero operands.
//
//   Ports:
//     clock, reset          : clock; synchronous active-high reset (also the
//                             core's reset)
//     in_valid/in_ready     : operand handshake, in_ready high only in IDLE
//     in_a, in_b     [W]    : operands
//     out_valid/out_ready   : result handshake, output held until taken
//     out_result     [W]    : gcd(a,b)
//     out_cycles     [CW]   : cycles from accept to out_valid, saturating
//     gcd_req        out    : core req
//     gcd_ack        in     : core ack
//     gcd_load_val   [W]    : core loadVal
//     gcd_result     [W]    : core result
// ----------------------------------------------------------------------------
module gcd_client
  import gcd_client_pkg::*;
#(
  parameter int W  = GCD_W_DEFAULT,
  parameter int CW = GCD_CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [CW-1:0] out_cycles,
  output logic          gcd_req,
  input  logic          gcd_ack,
  output logic [W-1:0]  gcd_load_val,
  input  logic [W-1:0]  gcd_result
);

  state_t        state_reg;
  state_t        state_next;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  r_reg;
  logic [CW-1:0] cnt;

  logic          accept;        // operand pair taken this cycle
  logic          latch_result;  // core result valid this cycle
  logic          bypass;        // current input pair resolved locally

`ifdef GCD_CLIENT_ZERO_BYPASS_EN
  // gcd(0,x) = x and gcd(0,0) = 0, so an OR of the operands is the answer.
  assign bypass = (in_a == '0) || (in_b == '0);
`else
  assign bypass = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer. gcd_req is decoded from state_reg alone, so there is no
  // combinational path from gcd_ack to gcd_req, and req can only rise after
  // the state machine has already seen ack low in the previous REL state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_result   = '0;
    out_cycles   = '0;
    gcd_req      = 1'b0;
    gcd_load_val = '0;
    accept       = 1'b0;
    latch_result = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = bypass ? RESP : REQ_A;
        end
      end

      REQ_A: begin
        gcd_req      = 1'b1;
        gcd_load_val = a_reg;
        if (gcd_ack) begin
          state_next = REL_A;
        end
      end

      REL_A: begin
        gcd_load_val = a_reg;
        if (!gcd_ack) begin
          state_next = REQ_B;
        end
      end

      REQ_B: begin
        gcd_req      = 1'b1;
        gcd_load_val = b_reg;
        if (gcd_ack) begin
          latch_result = 1'b1;
          state_next   = REL_B;
        end
      end

      REL_B: begin
        gcd_load_val = b_reg;
        if (!gcd_ack) begin
          state_next = RESP;
        end
      end

      RESP: begin
        out_valid  = 1'b1;
        out_result = r_reg;
        out_cycles = cnt;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand and result registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
        if (bypass) begin
          r_reg <= in_a | in_b;
        end
      end
      if (latch_result) begin
        r_reg <= gcd_result;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Latency measurement: restarted at 1 on accept, then runs while the
  // sequencer is busy with the core.
  // --------------------------------------------------------------------------
  gcd_lat_counter #(
    .CW (CW)
  ) u_lat_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (state_counts(state_reg)),
    .count  (cnt)
  );

endmodule
